// File: rtl/sram_lat_pkg.sv
// Shared types and address decode helpers for the latency-configurable SRAM slave.
// Decode helpers take the window geometry as arguments so any instance can reuse them.
package sram_lat_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    // Addresses are widened to 64 bits so one helper serves every ADDR_W up to 64.
    function automatic logic addr_ok(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int          depth_log2,
        input int          bytes_log2
    );
        return (addr >= base)
            && (((addr - base) >> (depth_log2 + bytes_log2)) == 64'd0)
            && ((addr & ((64'd1 << bytes_log2) - 64'd1)) == 64'd0);
    endfunction

    function automatic logic [31:0] addr_idx(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int          bytes_log2
    );
        return 32'((addr - base) >> bytes_log2);
    endfunction

endpackage

// File: rtl/sram_lat_ctrl.sv
// One channel's request/response sequencer: response LATENCY cycles after accept,
// holds resp_valid until resp_ready and keeps req_ready low meanwhile.
module sram_lat_ctrl
    import sram_lat_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic resp_ready,
    output logic req_ready,
    output logic resp_valid,
    output logic access
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    // The array is touched on the same edge that moves the channel into S_RESP;
    // cnt==1 in S_WAIT means the decrement about to happen brings it to zero.
    assign access = ((state == S_IDLE) && req_valid && (LATENCY == 1))
                 || ((state == S_WAIT) && (cnt == CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cnt       <= CNT_W'(LATENCY - 1);
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    cnt        <= '0;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sram_lat.sv
// Word-array SRAM slave with independent read/write channels, byte strobes and range errors;
// fixed LATENCY-cycle response, each channel stalls only on its own resp_ready.
module sram_lat
    import sram_lat_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH_LOG2 = 10,
    parameter int                LATENCY    = 1,
    parameter logic [ADDR_W-1:0] BASE       = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_req_valid,
    output logic                rd_req_ready,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_resp_valid,
    input  logic                rd_resp_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_err,
    input  logic                wr_req_valid,
    output logic                wr_req_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    output logic                wr_resp_valid,
    input  logic                wr_resp_ready,
    output logic                wr_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int BL2   = $clog2(BYTES);
    localparam int WORDS = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [WORDS];

    logic rd_acc, wr_acc;

    sram_lat_ctrl #(.LATENCY(LATENCY)) u_rd_ctrl (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (rd_req_valid),
        .resp_ready (rd_resp_ready),
        .req_ready  (rd_req_ready),
        .resp_valid (rd_resp_valid),
        .access     (rd_acc)
    );

    sram_lat_ctrl #(.LATENCY(LATENCY)) u_wr_ctrl (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (wr_req_valid),
        .resp_ready (wr_resp_ready),
        .req_ready  (wr_req_ready),
        .resp_valid (wr_resp_valid),
        .access     (wr_acc)
    );

    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [BYTES-1:0]  wr_strb_q;

    always_ff @(posedge clk) begin
        if (rd_req_valid && rd_req_ready) rd_addr_q <= rd_addr;
        if (wr_req_valid && wr_req_ready) begin
            wr_addr_q <= wr_addr;
            wr_data_q <= wr_data;
            wr_strb_q <= wr_strb;
        end
    end

    // With LATENCY=1 the access coincides with accept, so bypass the capture registers.
    logic [ADDR_W-1:0] rd_a, wr_a;
    logic [DATA_W-1:0] wr_d;
    logic [BYTES-1:0]  wr_s;
    assign rd_a = rd_req_ready ? rd_addr : rd_addr_q;
    assign wr_a = wr_req_ready ? wr_addr : wr_addr_q;
    assign wr_d = wr_req_ready ? wr_data : wr_data_q;
    assign wr_s = wr_req_ready ? wr_strb : wr_strb_q;

    logic                  rd_ok, wr_ok;
    logic [31:0]           rd_idx_full, wr_idx_full;
    logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;
    logic                  unused_idx_bits;

    assign rd_ok       = addr_ok(64'(rd_a), 64'(BASE), DEPTH_LOG2, BL2);
    assign wr_ok       = addr_ok(64'(wr_a), 64'(BASE), DEPTH_LOG2, BL2);
    assign rd_idx_full = addr_idx(64'(rd_a), 64'(BASE), BL2);
    assign wr_idx_full = addr_idx(64'(wr_a), 64'(BASE), BL2);
    assign rd_idx      = rd_idx_full[DEPTH_LOG2-1:0];
    assign wr_idx      = wr_idx_full[DEPTH_LOG2-1:0];
    assign unused_idx_bits = ^{rd_idx_full[31:DEPTH_LOG2], wr_idx_full[31:DEPTH_LOG2]};

    logic [DATA_W-1:0] wr_merged;
    always_comb begin
        wr_merged = mem[wr_idx];
        for (int i = 0; i < BYTES; i++) begin
            if (wr_s[i]) wr_merged[8*i +: 8] = wr_d[8*i +: 8];
        end
    end

    // Reset on the access edge discards a write that has not yet reached S_RESP.
    always_ff @(posedge clk) begin
        if (wr_acc && wr_ok && !rst) mem[wr_idx] <= wr_merged;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            rd_err  <= 1'b0;
            wr_err  <= 1'b0;
        end else begin
            if (rd_acc) begin
                rd_err  <= !rd_ok;
                rd_data <= rd_ok ? mem[rd_idx] : '0;
            end
            if (wr_acc) wr_err <= !wr_ok;
        end
    end

endmodule

// File: tb/tb_sram_lat.sv
// Directed bench: LATENCY=3 instance for the vector table and back-pressure,
// LATENCY=1 for the same-edge collision, LATENCY=4 for reset mid-write.
module tb_sram_lat;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0;
    logic [3:0]  wr_strb = '0;
    logic        rd_resp_ready = 1'b1, wr_resp_ready = 1'b1;

    logic        rd_req_valid [3];
    logic        wr_req_valid [3];
    logic        rd_req_ready [3];
    logic        wr_req_ready [3];
    logic        rd_resp_valid[3];
    logic        wr_resp_valid[3];
    logic [31:0] rd_data      [3];
    logic        rd_err       [3];
    logic        wr_err       [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_lat #(.LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid[0]), .rd_req_ready(rd_req_ready[0]), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid[0]), .rd_resp_ready(rd_resp_ready),
        .rd_data(rd_data[0]), .rd_err(rd_err[0]),
        .wr_req_valid(wr_req_valid[0]), .wr_req_ready(wr_req_ready[0]), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_resp_valid(wr_resp_valid[0]), .wr_resp_ready(wr_resp_ready), .wr_err(wr_err[0])
    );

    sram_lat #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid[1]), .rd_req_ready(rd_req_ready[1]), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid[1]), .rd_resp_ready(rd_resp_ready),
        .rd_data(rd_data[1]), .rd_err(rd_err[1]),
        .wr_req_valid(wr_req_valid[1]), .wr_req_ready(wr_req_ready[1]), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_resp_valid(wr_resp_valid[1]), .wr_resp_ready(wr_resp_ready), .wr_err(wr_err[1])
    );

    sram_lat #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid[2]), .rd_req_ready(rd_req_ready[2]), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid[2]), .rd_resp_ready(rd_resp_ready),
        .rd_data(rd_data[2]), .rd_err(rd_err[2]),
        .wr_req_valid(wr_req_valid[2]), .wr_req_ready(wr_req_ready[2]), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_resp_valid(wr_resp_valid[2]), .wr_resp_ready(wr_resp_ready), .wr_err(wr_err[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_wr(input int k, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic err, output int lat);
        int n;
        @(negedge clk);
        wr_addr = a; wr_data = d; wr_strb = s; wr_req_valid[k] = 1'b1;
        n = 0;
        while (!wr_req_ready[k] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 wr_req_valid[k] = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!wr_resp_valid[k] && lat < 50);
        err = wr_err[k];
        @(posedge clk); #1;
    endtask

    task automatic do_rd(input int k, input logic [31:0] a,
                         output logic [31:0] d, output logic err, output int lat);
        int n;
        @(negedge clk);
        rd_addr = a; rd_req_valid[k] = 1'b1;
        n = 0;
        while (!rd_req_ready[k] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 rd_req_valid[k] = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rd_resp_valid[k] && lat < 50);
        d = rd_data[k];
        err = rd_err[k];
        @(posedge clk); #1;
    endtask

    task automatic hold_chk(input int cycles, input logic [31:0] exp);
        repeat (cycles) begin
            @(negedge clk);
            check("bp_rd_resp_valid", 32'(rd_resp_valid[0]), 32'd1);
            check("bp_rd_data", rd_data[0], exp);
            check("bp_rd_req_ready", 32'(rd_req_ready[0]), 32'd0);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;   // write data, or expected read data
        logic [3:0]  strb;
        bit          err;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        int          seen;

        for (int k = 0; k < 3; k++) begin
            rd_req_valid[k] = 1'b0;
            wr_req_valid[k] = 1'b0;
        end

        vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0};
        vecs[1]  = '{1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'h0, 1'b0};
        vecs[2]  = '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 1'b0};
        vecs[3]  = '{1'b0, 32'h8000_0010, 32'hDE22_BE44, 4'h0, 1'b0};
        vecs[4]  = '{1'b0, 32'h7FFF_FFFC, 32'h0000_0000, 4'h0, 1'b1};
        vecs[5]  = '{1'b1, 32'h8000_0012, 32'hFFFF_FFFF, 4'hF, 1'b1};
        vecs[6]  = '{1'b0, 32'h8000_0010, 32'hDE22_BE44, 4'h0, 1'b0};
        vecs[7]  = '{1'b1, 32'h8000_0010, 32'h0000_0000, 4'h0, 1'b0};
        vecs[8]  = '{1'b0, 32'h8000_0010, 32'hDE22_BE44, 4'h0, 1'b0};
        vecs[9]  = '{1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'b1010, 1'b0};
        vecs[10] = '{1'b0, 32'h8000_0010, 32'hAA22_CC44, 4'h0, 1'b0};
        vecs[11] = '{1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 1'b0};
        vecs[12] = '{1'b0, 32'h8000_0FFC, 32'hCAFE_F00D, 4'h0, 1'b0};
        vecs[13] = '{1'b0, 32'h8000_1000, 32'h0000_0000, 4'h0, 1'b1};
        vecs[14] = '{1'b1, 32'h8000_1000, 32'h5555_5555, 4'hF, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("rst_rd_req_ready",  32'(rd_req_ready[k]),  32'd1);
            check("rst_wr_req_ready",  32'(wr_req_ready[k]),  32'd1);
            check("rst_rd_resp_valid", 32'(rd_resp_valid[k]), 32'd0);
            check("rst_wr_resp_valid", 32'(wr_resp_valid[k]), 32'd0);
            check("rst_rd_data",       rd_data[k],            32'd0);
            check("rst_rd_err",        32'(rd_err[k]),        32'd0);
            check("rst_wr_err",        32'(wr_err[k]),        32'd0);
        end

        // Vector table on the LATENCY=3 instance
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                do_wr(0, vecs[i].addr, vecs[i].data, vecs[i].strb, e, lat);
                check($sformatf("vec%0d_wr_err", i), 32'(e), 32'(vecs[i].err));
                check($sformatf("vec%0d_wr_lat", i), 32'(lat), 32'd3);
            end else begin
                do_rd(0, vecs[i].addr, d, e, lat);
                check($sformatf("vec%0d_rd_err", i), 32'(e), 32'(vecs[i].err));
                check($sformatf("vec%0d_rd_data", i), d, vecs[i].data);
                check($sformatf("vec%0d_rd_lat", i), 32'(lat), 32'd3);
            end
        end

        // Back-pressure on the read channel while the write channel completes
        rd_resp_ready = 1'b0;
        @(negedge clk);
        rd_addr = 32'h8000_0010; rd_req_valid[0] = 1'b1;
        @(posedge clk); #1 rd_req_valid[0] = 1'b0;
        seen = 0;
        do begin @(negedge clk); seen++; end while (!rd_resp_valid[0] && seen < 20);
        check("bp_first_lat", 32'(seen), 32'd3);
        hold_chk(2, 32'hAA22_CC44);
        do_wr(0, 32'h8000_0014, 32'h0123_4567, 4'hF, e, lat);
        check("bp_wr_err", 32'(e), 32'd0);
        check("bp_wr_lat", 32'(lat), 32'd3);
        hold_chk(3, 32'hAA22_CC44);
        rd_resp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_release_valid", 32'(rd_resp_valid[0]), 32'd0);
        check("bp_release_ready", 32'(rd_req_ready[0]), 32'd1);
        do_rd(0, 32'h8000_0014, d, e, lat);
        check("bp_wr_readback", d, 32'h0123_4567);

        // Same-edge read/write collision on the LATENCY=1 instance
        do_wr(1, 32'h8000_0020, 32'h0000_0001, 4'hF, e, lat);
        check("l1_wr_lat", 32'(lat), 32'd1);
        @(negedge clk);
        rd_addr = 32'h8000_0020; wr_addr = 32'h8000_0020;
        wr_data = 32'hFFFF_FFFF; wr_strb = 4'hF;
        rd_req_valid[1] = 1'b1; wr_req_valid[1] = 1'b1;
        @(posedge clk); #1 rd_req_valid[1] = 1'b0; wr_req_valid[1] = 1'b0;
        @(negedge clk);
        check("coll_rd_valid", 32'(rd_resp_valid[1]), 32'd1);
        check("coll_wr_valid", 32'(wr_resp_valid[1]), 32'd1);
        check("coll_rd_data_old", rd_data[1], 32'h0000_0001);
        check("coll_wr_err", 32'(wr_err[1]), 32'd0);
        @(posedge clk); #1;
        do_rd(1, 32'h8000_0020, d, e, lat);
        check("coll_rd_data_new", d, 32'hFFFF_FFFF);
        check("coll_rd_lat", 32'(lat), 32'd1);

        // Reset two cycles after a LATENCY=4 write is accepted
        do_wr(2, 32'h8000_0030, 32'hA5A5_A5A5, 4'hF, e, lat);
        check("l4_wr_lat", 32'(lat), 32'd4);
        @(negedge clk);
        wr_addr = 32'h8000_0030; wr_data = 32'h5A5A_5A5A; wr_strb = 4'hF;
        wr_req_valid[2] = 1'b1;
        @(posedge clk); #1 wr_req_valid[2] = 1'b0;
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("mid_rst_wr_ready", 32'(wr_req_ready[2]), 32'd1);
        check("mid_rst_rd_ready", 32'(rd_req_ready[2]), 32'd1);
        check("mid_rst_wr_valid", 32'(wr_resp_valid[2]), 32'd0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (wr_resp_valid[2]) seen++;
        end
        check("mid_rst_no_wr_resp", 32'(seen), 32'd0);
        do_rd(2, 32'h8000_0030, d, e, lat);
        check("mid_rst_word_kept", d, 32'hA5A5_A5A5);
        check("mid_rst_rd_lat", 32'(lat), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
